// File: rtl/pri_rv32_exu.sv
// RV32I execute stage: one-hot decoded instruction in, registered result/next-PC and store data out.
// Optional CSR support is enabled by defining PRIRV32_EXU_CSR_EN.
module pri_rv32_exu (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [46:0] instrset_latched,
    input  logic [31:0] imm_decoded,
    input  logic [31:0] rs1_decoded,
    input  logic [31:0] rs2_decoded,
    input  logic [31:0] pc_latched,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_readwrite_address,
    output logic [31:0] rd_reg,
    output logic [31:0] rs2_reg
);

    // Encodings equal the bit index in instrset_latched.
    typedef enum logic [5:0] {
        OP_CSRRCI = 6'd0, OP_CSRRSI, OP_CSRRWI, OP_CSRRC, OP_CSRRS, OP_CSRRW,
        OP_EBREAK, OP_ECALL, OP_FENCEI, OP_FENCE,
        OP_AND, OP_OR, OP_SRA, OP_SRL, OP_XOR, OP_SLTU, OP_SLT, OP_SLL, OP_SUB, OP_ADD,
        OP_SRAI, OP_SRLI, OP_SLLI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU, OP_SLTI, OP_ADDI,
        OP_SW, OP_SH, OP_SB, OP_LHU, OP_LBU, OP_LW, OP_LH, OP_LB,
        OP_BGEU, OP_BLTU, OP_BGE, OP_BLT, OP_BNE, OP_BEQ,
        OP_JALR, OP_JAL, OP_AUIPC, OP_LUI
    } op_e;

    logic [31:0] rd_q, rd_d;
    logic [31:0] rs2_q, rs2_d;
`ifdef PRIRV32_EXU_CSR_EN
    logic [31:0] csr_q, csr_d;
`endif

    op_e         op;
    logic        op_valid;
    logic        ls_active;
    logic [31:0] ea;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic [4:0]  shamt_r;
    logic [4:0]  shamt_i;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        eq;
    logic        lt_s;
    logic        lt_u;
    logic [31:0] zimm;

    // Later (higher-index) set bits overwrite earlier ones, so the highest bit wins.
    always_comb begin
        op       = OP_LUI;
        op_valid = 1'b0;
        for (int unsigned i = 0; i < 47; i++) begin
            if (instrset_latched[i]) begin
                op       = op_e'(6'(i));
                op_valid = 1'b1;
            end
        end
    end

    assign ls_active             = |instrset_latched[36:29];
    assign ea                    = rs1_decoded + imm_decoded;
    assign mem_readwrite_address = ls_active ? ea : '0;

    assign pc_plus4    = pc_latched + 32'd4;
    assign pc_plus_imm = pc_latched + imm_decoded;
    assign shamt_r     = rs2_decoded[4:0];
    assign shamt_i     = imm_decoded[4:0];
    assign eq          = (rs1_decoded == rs2_decoded);
    assign lt_s        = ($signed(rs1_decoded) < $signed(rs2_decoded));
    assign lt_u        = (rs1_decoded < rs2_decoded);
    assign zimm        = {27'd0, imm_decoded[16:12]};

    always_comb begin
        case (ea[1:0])
            2'd0:    ld_byte = mem_read_data[7:0];
            2'd1:    ld_byte = mem_read_data[15:8];
            2'd2:    ld_byte = mem_read_data[23:16];
            default: ld_byte = mem_read_data[31:24];
        endcase
        ld_half = ea[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    end

    always_comb begin
        rd_d  = rd_q;
        rs2_d = rs2_q;
`ifdef PRIRV32_EXU_CSR_EN
        csr_d = csr_q;
`endif
        if (op_valid) begin
            case (op)
                OP_LUI:   rd_d = imm_decoded;
                OP_AUIPC: rd_d = pc_plus_imm;
                OP_JAL, OP_JALR: rd_d = pc_plus4;
                OP_BEQ:   rd_d = eq    ? pc_plus_imm : pc_plus4;
                OP_BNE:   rd_d = !eq   ? pc_plus_imm : pc_plus4;
                OP_BLT:   rd_d = lt_s  ? pc_plus_imm : pc_plus4;
                OP_BGE:   rd_d = !lt_s ? pc_plus_imm : pc_plus4;
                OP_BLTU:  rd_d = lt_u  ? pc_plus_imm : pc_plus4;
                OP_BGEU:  rd_d = !lt_u ? pc_plus_imm : pc_plus4;
                OP_LB:    rd_d = {{24{ld_byte[7]}}, ld_byte};
                OP_LH:    rd_d = {{16{ld_half[15]}}, ld_half};
                OP_LW:    rd_d = mem_read_data;
                OP_LBU:   rd_d = {24'd0, ld_byte};
                OP_LHU:   rd_d = {16'd0, ld_half};
                OP_SB:    rs2_d = {4{rs2_decoded[7:0]}};
                OP_SH:    rs2_d = {2{rs2_decoded[15:0]}};
                OP_SW:    rs2_d = rs2_decoded;
                OP_ADDI:  rd_d = ea;
                OP_SLTI:  rd_d = {31'd0, $signed(rs1_decoded) < $signed(imm_decoded)};
                OP_SLTIU: rd_d = {31'd0, rs1_decoded < imm_decoded};
                OP_XORI:  rd_d = rs1_decoded ^ imm_decoded;
                OP_ORI:   rd_d = rs1_decoded | imm_decoded;
                OP_ANDI:  rd_d = rs1_decoded & imm_decoded;
                OP_SLLI:  rd_d = rs1_decoded << shamt_i;
                OP_SRLI:  rd_d = rs1_decoded >> shamt_i;
                OP_SRAI:  rd_d = 32'($signed(rs1_decoded) >>> shamt_i);
                OP_ADD:   rd_d = rs1_decoded + rs2_decoded;
                OP_SUB:   rd_d = rs1_decoded - rs2_decoded;
                OP_SLL:   rd_d = rs1_decoded << shamt_r;
                OP_SLT:   rd_d = {31'd0, lt_s};
                OP_SLTU:  rd_d = {31'd0, lt_u};
                OP_XOR:   rd_d = rs1_decoded ^ rs2_decoded;
                OP_SRL:   rd_d = rs1_decoded >> shamt_r;
                OP_SRA:   rd_d = 32'($signed(rs1_decoded) >>> shamt_r);
                OP_OR:    rd_d = rs1_decoded | rs2_decoded;
                OP_AND:   rd_d = rs1_decoded & rs2_decoded;
                OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI: begin
`ifdef PRIRV32_EXU_CSR_EN
                    rd_d = csr_q;
                    case (op)
                        OP_CSRRW:  csr_d = rs1_decoded;
                        OP_CSRRS:  csr_d = csr_q | rs1_decoded;
                        OP_CSRRC:  csr_d = csr_q & ~rs1_decoded;
                        OP_CSRRWI: csr_d = zimm;
                        OP_CSRRSI: csr_d = csr_q | zimm;
                        default:   csr_d = csr_q & ~zimm;
                    endcase
`else
                    rd_d = '0;
`endif
                end
                default:  rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            rs2_q <= '0;
`ifdef PRIRV32_EXU_CSR_EN
            csr_q <= '0;
`endif
        end else begin
            rd_q  <= rd_d;
            rs2_q <= rs2_d;
`ifdef PRIRV32_EXU_CSR_EN
            csr_q <= csr_d;
`endif
        end
    end

    assign rd_reg  = rd_q;
    assign rs2_reg = rs2_q;

endmodule

// File: tb/tb_pri_rv32_exu.sv
// Scoreboard bench for pri_rv32_exu: stimulus queues hand-computed results, a monitor checks them.
module tb_pri_rv32_exu;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [46:0] instrset_latched;
    logic [31:0] imm_decoded, rs1_decoded, rs2_decoded, pc_latched, mem_read_data;
    logic [31:0] mem_readwrite_address, rd_reg, rs2_reg;

    pri_rv32_exu dut (
        .clk_i                 (clk_i),
        .rst_n                 (rst_n),
        .instrset_latched      (instrset_latched),
        .imm_decoded           (imm_decoded),
        .rs1_decoded           (rs1_decoded),
        .rs2_decoded           (rs2_decoded),
        .pc_latched            (pc_latched),
        .mem_read_data         (mem_read_data),
        .mem_readwrite_address (mem_readwrite_address),
        .rd_reg                (rd_reg),
        .rs2_reg               (rs2_reg)
    );

    always #5 clk_i = ~clk_i;

    localparam int I_LUI = 46, I_AUIPC = 45, I_JAL = 44, I_BNE = 41, I_BLT = 40, I_BLTU = 38;
    localparam int I_LB = 36, I_LH = 35, I_LW = 34, I_LBU = 33, I_LHU = 32;
    localparam int I_SB = 31, I_SH = 30, I_SW = 29, I_ADDI = 28, I_SLLI = 22, I_SRAI = 20;
    localparam int I_ADD = 19, I_SUB = 18, I_SLT = 16, I_SLTU = 15, I_SRA = 12, I_ECALL = 7;
    localparam int I_CSRRW = 5, I_CSRRS = 4, I_CSRRCI = 0;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic [31:0] rs2;
        logic [31:0] addr;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [46:0] ins,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] mem, input logic [31:0] erd,
                         input logic [31:0] ers2, input logic [31:0] eaddr);
        exp_t e;
        @(negedge clk_i);
        instrset_latched = ins;
        rs1_decoded      = rs1;
        rs2_decoded      = rs2;
        imm_decoded      = imm;
        pc_latched       = pc;
        mem_read_data    = mem;
        e.name = nm; e.rd = erd; e.rs2 = ers2; e.addr = eaddr;
        q.push_back(e);
    endtask

    function automatic logic [46:0] op1(input int idx);
        return 47'd1 << idx;
    endfunction

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge clk_i);
            n++;
        end
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
    endtask

    // Monitor: results of the instruction driven before each rising edge are visible just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.name, ".rd"},   rd_reg,                e.rd);
                check({e.name, ".rs2"},  rs2_reg,               e.rs2);
                check({e.name, ".addr"}, mem_readwrite_address, e.addr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] csr_a5, csr_1a5, csr_1a0;
`ifdef PRIRV32_EXU_CSR_EN
        csr_a5 = 32'hA5; csr_1a5 = 32'h1A5; csr_1a0 = 32'h1A0;
`else
        csr_a5 = 32'h0; csr_1a5 = 32'h0; csr_1a0 = 32'h0;
`endif
        rst_n = 1'b0;
        instrset_latched = '0; imm_decoded = '0; rs1_decoded = '0;
        rs2_decoded = '0; pc_latched = '0; mem_read_data = '0;
        #3;
        check("reset.rd",  rd_reg,  32'h0);
        check("reset.rs2", rs2_reg, 32'h0);
        rst_n = 1'b1;
        @(posedge clk_i); #1;
        check("post_reset.rd",  rd_reg,  32'h0);
        check("post_reset.rs2", rs2_reg, 32'h0);

        issue("idle0", '0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        issue("add_ovf", op1(I_ADD), 32'h7FFFFFFF, 32'h1, 0, 0, 0, 32'h80000000, 32'h0, 32'h0);
        issue("sra", op1(I_SRA), 32'h80000000, 32'h21, 0, 0, 0, 32'hC0000000, 32'h0, 32'h0);
        issue("sltu", op1(I_SLTU), 32'h1, 32'hFFFFFFFF, 0, 0, 0, 32'h1, 32'h0, 32'h0);
        issue("slt", op1(I_SLT), 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h1, 32'h0, 32'h0);
        issue("sub", op1(I_SUB), 32'h0, 32'h1, 0, 0, 0, 32'hFFFFFFFF, 32'h0, 32'h0);
        issue("srai", op1(I_SRAI), 32'hF0000000, 0, 32'h24, 0, 0, 32'hFF000000, 32'h0, 32'h0);
        issue("slli", op1(I_SLLI), 32'h1, 0, 32'd31, 0, 0, 32'h80000000, 32'h0, 32'h0);
        issue("bne", op1(I_BNE), 32'h3, 32'h3, 32'h20, 32'h100, 0, 32'h104, 32'h0, 32'h0);
        issue("blt", op1(I_BLT), 32'hFFFFFFFF, 32'h0, 32'h20, 32'h100, 0, 32'h120, 32'h0, 32'h0);
        issue("bltu", op1(I_BLTU), 32'hFFFFFFFF, 32'h0, 32'h20, 32'h100, 0, 32'h104, 32'h0, 32'h0);
        issue("jal", op1(I_JAL), 0, 0, 32'h20, 32'h100, 0, 32'h104, 32'h0, 32'h0);
        issue("auipc", op1(I_AUIPC), 0, 0, 32'h20, 32'h100, 0, 32'h120, 32'h0, 32'h0);
        issue("lui", op1(I_LUI), 0, 0, 32'h12345000, 0, 0, 32'h12345000, 32'h0, 32'h0);
        issue("lb", op1(I_LB), 32'h1000, 0, 32'd3, 0, 32'h80FF0000, 32'hFFFFFF80, 32'h0, 32'h1003);
        issue("lhu", op1(I_LHU), 32'h1000, 0, 32'd2, 0, 32'h80FF0000, 32'h000080FF, 32'h0, 32'h1002);
        issue("lh", op1(I_LH), 32'h1000, 0, 32'd2, 0, 32'h80FF0000, 32'hFFFF80FF, 32'h0, 32'h1002);
        issue("lw", op1(I_LW), 32'h1000, 0, 32'd0, 0, 32'h80FF0000, 32'h80FF0000, 32'h0, 32'h1000);
        issue("lbu", op1(I_LBU), 32'h1000, 0, 32'd2, 0, 32'h80FF0000, 32'h000000FF, 32'h0, 32'h1002);
        issue("sb", op1(I_SB), 32'h2000, 32'h12345678, 32'd1, 0, 0, 32'h000000FF, 32'h78787878, 32'h2001);
        issue("sh", op1(I_SH), 32'h2000, 32'h12345678, 32'd1, 0, 0, 32'h000000FF, 32'h56785678, 32'h2001);
        issue("sw", op1(I_SW), 32'h2000, 32'hDEADBEEF, 32'd0, 0, 0, 32'h000000FF, 32'hDEADBEEF, 32'h2000);
        issue("idle1", '0, 32'h5, 32'h6, 32'h7, 0, 0, 32'h000000FF, 32'hDEADBEEF, 32'h0);
        issue("ecall", op1(I_ECALL), 32'h5, 32'h6, 32'h7, 0, 0, 32'h0, 32'hDEADBEEF, 32'h0);
        issue("prio", op1(I_LUI) | op1(I_ADD), 32'h1, 32'h1, 32'hABCDE000, 0, 0,
              32'hABCDE000, 32'hDEADBEEF, 32'h0);
        issue("addi_wrap", op1(I_ADDI), 32'hFFFFFFFF, 0, 32'h1, 0, 0, 32'h0, 32'hDEADBEEF, 32'h0);
        issue("csrrw", op1(I_CSRRW), 32'hA5, 0, 0, 0, 0, 32'h0, 32'hDEADBEEF, 32'h0);
        issue("csrrs", op1(I_CSRRS), 32'h100, 0, 0, 0, 0, csr_a5, 32'hDEADBEEF, 32'h0);
        issue("csrrci", op1(I_CSRRCI), 32'hFFFFFFFF, 0, 32'h5000, 0, 0, csr_1a5, 32'hDEADBEEF, 32'h0);
        issue("csr_read", op1(I_CSRRS), 32'h0, 0, 0, 0, 0, csr_1a0, 32'hDEADBEEF, 32'h0);
        drain();

        @(negedge clk_i);
        instrset_latched = op1(I_SW);
        rs1_decoded = 32'h1; rs2_decoded = 32'h2; imm_decoded = '0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset.rd",  rd_reg,  32'h0);
        check("async_reset.rs2", rs2_reg, 32'h0);
        @(posedge clk_i); #1;
        check("in_reset.rs2", rs2_reg, 32'h0);
        @(negedge clk_i);
        rst_n = 1'b1;
        instrset_latched = '0;
        @(posedge clk_i); #1;
        check("release_hold.rd",  rd_reg,  32'h0);
        check("release_hold.rs2", rs2_reg, 32'h0);

        issue("csr_after_reset", op1(I_CSRRS), 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        issue("add_after_reset", op1(I_ADD), 32'h1, 32'h2, 0, 0, 0, 32'h3, 32'h0, 32'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
